// File: rtl/xbus_dma_engine.sv
// xbus_dma_engine
// Sequential single-word XBUS master. A block command (word address, length,
// direction) is broken into one bus transaction per word. Read mode streams
// memory words out through rd_*; write mode collects words from wr_* and
// writes them to memory. A small FIFO sits between the stream side and the bus.
//
// Stream handshakes (rd_* and wr_*): a word moves on every clock edge where
// valid and ready are both high. The producer holds data stable while valid is
// high and ready is low. The consumer's ready may change at any time.
//
// Bus side: ma_req is raised only when the engine can actually launch a word.
// That means the FIFO is not full in read mode, or not empty in write mode. So
// ma_req stays low while the read stream is stalled. A grant in REQ moves the
// FSM to XFER. ma_select and the address/data/direction are then held until
// xbm_ack. After every transfer there is one GAP cycle with ma_select low.

module xbus_dma_engine #(
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_LEN_WIDTH  = 16
) (
    input  logic                   Bus2IP_Mst_Clk,
    input  logic                   Bus2IP_Mst_Reset,
    // command
    input  logic                   cmd_start,
    input  logic                   cmd_rnw,
    input  logic [31:0]            cmd_addr,
    input  logic [C_LEN_WIDTH-1:0] cmd_len,
    output logic                   busy,
    output logic                   done,
    // read stream (memory -> ICAP)
    output logic [31:0]            rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    // write stream (ICAP -> memory)
    input  logic [31:0]            wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    // XBUS master side
    output logic                   ma_req,
    output logic                   ma_select,
    output logic                   ma_rnw,
    output logic [31:0]            ma_addr,
    output logic [31:0]            ma_data,
    output logic [3:0]             ma_be,
    input  logic                   xbm_gnt,
    input  logic                   xbm_ack,
    input  logic [31:0]            xbm_data,
    // debug: current FSM state
    output logic [2:0]             o_dbg_state
);

    localparam int L_PW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int L_CW = L_PW + 1;

    localparam logic [L_CW-1:0]        L_CNT_FULL = L_CW'(C_FIFO_DEPTH);
    localparam logic [L_CW-1:0]        L_CNT_ZERO = '0;
    localparam logic [L_CW-1:0]        L_CNT_ONE  = L_CW'(1);
    localparam logic [L_PW-1:0]        L_PTR_ONE  = L_PW'(1);
    localparam logic [C_LEN_WIDTH-1:0] L_LEN_ZERO = '0;
    localparam logic [C_LEN_WIDTH-1:0] L_LEN_ONE  = C_LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_XFER  = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // command / progress registers
    logic                   r_dir;
    logic [31:0]            r_cur_addr;
    logic [C_LEN_WIDTH-1:0] r_remaining;
    logic [C_LEN_WIDTH-1:0] r_len;
    logic [C_LEN_WIDTH-1:0] r_accepted;

    // FIFO storage
    logic [31:0]            r_mem [C_FIFO_DEPTH];
    logic [L_PW-1:0]        r_wptr;
    logic [L_PW-1:0]        r_rptr;
    logic [L_CW-1:0]        r_count;

    // registered outputs
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ma_req;
    logic                   r_ma_select;
    logic                   r_ma_rnw;
    logic [31:0]            r_ma_addr;
    logic [31:0]            r_ma_data;
    logic [3:0]             r_ma_be;

    // decoded control
    logic                   w_cmd_accept;
    logic                   w_ack_xfer;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_launch;
    logic                   w_rd_valid;
    logic                   w_rd_fire;
    logic                   w_wr_ready;
    logic                   w_wr_fire;
    logic                   w_push;
    logic                   w_pop;
    logic [31:0]            w_push_data;
    logic [31:0]            w_fifo_head;
    logic [L_CW-1:0]        w_count_nxt;
    logic                   w_dir_nxt;
    logic                   w_launch_nxt;
    logic                   w_launching;

    // next values of the registered outputs
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_ma_req_nxt;
    logic                   w_ma_select_nxt;
    logic                   w_ma_rnw_nxt;
    logic [31:0]            w_ma_addr_nxt;
    logic [31:0]            w_ma_data_nxt;
    logic [3:0]             w_ma_be_nxt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_cmd_accept = (r_state == S_IDLE) && cmd_start;
    assign w_ack_xfer   = (r_state == S_XFER) && xbm_ack;

    assign w_empty      = (r_count == L_CNT_ZERO);
    assign w_full       = (r_count == L_CNT_FULL);
    assign w_fifo_head  = r_mem[r_rptr];

    // A read needs room for the returning word. A write needs a word to send.
    assign w_launch     = r_dir ? !w_full : !w_empty;

    assign w_rd_valid   = r_dir && !w_empty;
    assign w_rd_fire    = w_rd_valid && rd_ready;

    // Never accept more stream words than the command asked for.
    assign w_wr_ready   = r_busy && !r_dir && !w_full && (r_accepted < r_len);
    assign w_wr_fire    = w_wr_ready && wr_valid;

    // The FIFO is filled by the bus and drained by the stream in read mode.
    // Write mode uses it in the opposite direction.
    assign w_push       = r_dir ? w_ack_xfer : w_wr_fire;
    assign w_pop        = r_dir ? w_rd_fire  : w_ack_xfer;
    assign w_push_data  = r_dir ? xbm_data   : wr_data;

    assign w_dir_nxt    = w_cmd_accept ? cmd_rnw : r_dir;
    assign w_launching  = (r_state == S_REQ) && (w_state_nxt == S_XFER);

    // Occupancy after this edge, used to decide ma_req one cycle ahead.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + L_CNT_ONE;
            2'b01:   w_count_nxt = r_count - L_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    assign w_launch_nxt = w_dir_nxt ? (w_count_nxt != L_CNT_FULL)
                                    : (w_count_nxt != L_CNT_ZERO);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge Bus2IP_Mst_Clk or posedge Bus2IP_Mst_Reset) begin
        if (Bus2IP_Mst_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // A zero-length command completes without touching the bus.
                if (cmd_start && (cmd_len != L_LEN_ZERO)) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (xbm_gnt && w_launch) begin
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (xbm_ack) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_remaining != L_LEN_ZERO) begin
                    w_state_nxt = S_REQ;
                end else if (r_dir) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                // The command finishes when the stream has taken the last word.
                if (w_empty) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: computes the value each registered output takes after this edge.
    always_comb begin
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_cmd_accept && (cmd_len == L_LEN_ZERO))
                       || ((r_state == S_GAP)   && (w_state_nxt == S_IDLE))
                       || ((r_state == S_DRAIN) && (w_state_nxt == S_IDLE));
        w_ma_select_nxt = (w_state_nxt == S_XFER);
        w_ma_req_nxt    = (w_state_nxt == S_XFER)
                       || ((w_state_nxt == S_REQ) && w_launch_nxt);
        w_ma_be_nxt     = (w_state_nxt == S_XFER) ? 4'hf : 4'h0;
        w_ma_addr_nxt   = r_ma_addr;
        w_ma_rnw_nxt    = r_ma_rnw;
        w_ma_data_nxt   = r_ma_data;
        if (w_launching) begin
            w_ma_addr_nxt = r_cur_addr;
            w_ma_rnw_nxt  = r_dir;
            w_ma_data_nxt = r_dir ? 32'h0 : w_fifo_head;
        end
    end

    // Output registers. The address, direction and data stay fixed between launch and ack.
    always_ff @(posedge Bus2IP_Mst_Clk or posedge Bus2IP_Mst_Reset) begin
        if (Bus2IP_Mst_Reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ma_req    <= 1'b0;
            r_ma_select <= 1'b0;
            r_ma_rnw    <= 1'b1;
            r_ma_addr   <= 32'h0;
            r_ma_data   <= 32'h0;
            r_ma_be     <= 4'h0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_ma_req    <= w_ma_req_nxt;
            r_ma_select <= w_ma_select_nxt;
            r_ma_rnw    <= w_ma_rnw_nxt;
            r_ma_addr   <= w_ma_addr_nxt;
            r_ma_data   <= w_ma_data_nxt;
            r_ma_be     <= w_ma_be_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Latch the command. Advance address and word count on every completed transfer.
    always_ff @(posedge Bus2IP_Mst_Clk or posedge Bus2IP_Mst_Reset) begin
        if (Bus2IP_Mst_Reset) begin
            r_dir       <= 1'b1;
            r_cur_addr  <= 32'h0;
            r_remaining <= L_LEN_ZERO;
            r_len       <= L_LEN_ZERO;
        end else if (w_cmd_accept) begin
            r_dir       <= cmd_rnw;
            r_cur_addr  <= cmd_addr;
            r_remaining <= cmd_len;
            r_len       <= cmd_len;
        end else if (w_ack_xfer) begin
            r_cur_addr  <= r_cur_addr + 32'd1;
            r_remaining <= r_remaining - L_LEN_ONE;
        end
    end

    // Count write-stream words taken for the current command.
    always_ff @(posedge Bus2IP_Mst_Clk or posedge Bus2IP_Mst_Reset) begin
        if (Bus2IP_Mst_Reset) begin
            r_accepted <= L_LEN_ZERO;
        end else if (w_cmd_accept) begin
            r_accepted <= L_LEN_ZERO;
        end else if (w_wr_fire) begin
            r_accepted <= r_accepted + L_LEN_ONE;
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge Bus2IP_Mst_Clk or posedge Bus2IP_Mst_Reset) begin
        if (Bus2IP_Mst_Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= L_CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + L_PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage. Cleared on reset so that rd_data reads zero after reset.
    always_ff @(posedge Bus2IP_Mst_Clk or posedge Bus2IP_Mst_Reset) begin
        if (Bus2IP_Mst_Reset) begin
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = r_busy;
    assign done        = r_done;
    assign rd_data     = w_fifo_head;
    assign rd_valid    = w_rd_valid;
    assign wr_ready    = w_wr_ready;
    assign ma_req      = r_ma_req;
    assign ma_select   = r_ma_select;
    assign ma_rnw      = r_ma_rnw;
    assign ma_addr     = r_ma_addr;
    assign ma_data     = r_ma_data;
    assign ma_be       = r_ma_be;
    assign o_dbg_state = r_state;

endmodule

// File: doc/xbus_dma_engine.md
# xbus_dma_engine

Sequential word-transfer engine that acts as the XBUS master feeding `xbus_masterif` inside `xps_icapi`. It takes a block command (word address, length, direction) and issues one single-word XBUS transaction at a time. In read mode it streams memory words (bitstream) toward the ICAP side; in write mode it writes streamed words (readback/state data) back to memory. A small FIFO decouples the stream side from bus latency.

## Interface
Parameters:
- C_FIFO_DEPTH, 4: FIFO depth in 32-bit words; power of two, ≥2.
- C_LEN_WIDTH, 16: width of the word-count field.

Ports:
- Bus2IP_Mst_Clk  in  1  clock.
- Bus2IP_Mst_Reset  in  1  reset, asynchronous, active-high.
- cmd_start  in  1  one-cycle command strobe; ignored while busy.
- cmd_rnw  in  1  1 = memory→stream (read), 0 = stream→memory (write).
- cmd_addr  in  32  start address in words.
- cmd_len  in  C_LEN_WIDTH  number of words.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- rd_data  out  32  read-stream data (FIFO head).
- rd_valid  out  1  read-stream valid.
- rd_ready  in  1  read-stream consumer ready.
- wr_data  in  32  write-stream data.
- wr_valid  in  1  write-stream valid.
- wr_ready  out  1  write-stream accept.
- ma_req, ma_select, ma_rnw  out  1  XBUS request, select, direction.
- ma_addr, ma_data  out  32  XBUS word address and write data.
- ma_be  out  4  byte enables.
- xbm_gnt, xbm_ack  in  1  XBUS grant; transfer-complete pulse.
- xbm_data  in  32  XBUS read data, valid in the xbm_ack cycle.

## Operation
- Command latch: on cmd_start while idle, register cmd_rnw, cmd_addr, cmd_len into dir, cur_addr, remaining. Set busy.
- FSM states: IDLE, REQ, XFER, GAP, DRAIN.
  - IDLE: waits for cmd_start. If cmd_len = 0, pulse done next cycle with no bus activity.
  - REQ: ma_req = 1. Launch condition: read mode, FIFO not full; write mode, FIFO not empty. When xbm_gnt = 1 and the launch condition holds, go to XFER.
  - XFER: ma_req = ma_select = 1. ma_addr = cur_addr, ma_rnw = dir, ma_be = 4'hf, ma_data = FIFO head in write mode. All held stable until xbm_ack.
    - On xbm_ack, read mode: push xbm_data into the FIFO.
    - On xbm_ack, write mode: pop the FIFO.
    - On xbm_ack, both modes: cur_addr += 1, remaining -= 1, go to GAP.
  - GAP: one cycle with ma_req = ma_select = 0. Then:
    - remaining ≠ 0 → REQ.
    - remaining = 0, read mode → DRAIN.
    - remaining = 0, write mode → IDLE, pulsing done.
  - DRAIN: read mode only. Waits for the FIFO to empty, then IDLE with done.
- Stream side:
  - Read: rd_valid = FIFO not empty; pop on rd_valid & rd_ready.
  - Write: wr_ready = busy & write mode & FIFO not full & accepted < len. The engine never over-accepts beyond cmd_len.
- Arithmetic: cur_addr is 32-bit and wraps 0xFFFFFFFF→0. remaining is C_LEN_WIDTH bits. FIFO count is log2(C_FIFO_DEPTH)+1 bits.
- Simultaneous FIFO push and pop in one cycle: count unchanged, both pointers advance.
- cmd_start while busy: ignored; no state change.
- Reset at any time: FSM → IDLE, FIFO cleared, counters zeroed, any transaction abandoned.

## Timing
- Reset values: busy 0, done 0, rd_valid 0, wr_ready 0, ma_req 0, ma_select 0, ma_rnw 1, ma_addr 0, ma_data 0, ma_be 0, rd_data 0.
- All outputs are registered, except rd_data (FIFO read port), rd_valid and wr_ready (decoded from registered count).
- cmd_start at edge N: busy = 1 and ma_req = 1 from N+1. With xbm_gnt = 1, ma_select = 1 from N+2.
- ma_select falls on the edge that samples xbm_ack. At least one deasserted cycle (GAP) precedes the next ma_select, which `xbus_masterif` needs to return to IDLE.
- Read data is visible on rd_data one cycle after the xbm_ack that pushed it.
- done is a single cycle. busy falls in the same cycle done is high.
- Throughput: one word per (bus latency + 2) cycles.

## Test plan
- Read, len 3, addr 0x100, rd_ready = 1, xbm_ack 4 cycles after each select → ma_addr 0x100, 0x101, 0x102; rd_data order matches xbm_data; one done; busy low after.
- Read, len 8, depth 4, rd_ready = 0 → exactly 4 transactions, then ma_req stays low. Raising rd_ready resumes; all 8 words delivered in order.
- Write, len 2, wr_valid held with 0xA5A5_0001 then 0xA5A5_0002 → ma_rnw = 0, ma_be = 4'hf, ma_data matches; wr_ready never high after 2 accepts.
- cmd_len = 0 → done one cycle after start; ma_req never asserted.
- addr 0xFFFFFFFF, len 2 → second ma_addr = 0x00000000. cmd_start pulsed mid-transfer is ignored.
- Reset asserted while ma_select = 1 → all outputs return to reset values immediately; a new command after release works normally.
